rtc_bus_sequencer: RTL and testbench



---
 rtl/rtc_pkg.sv | 73 +++++++
 rtl/rtc_bus_cycle.sv | 113 +++++++++++
 rtl/rtc_bus_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC bus sequencer.
// Holds the RTC register map, the top FSM and bus-phase encodings, the byte
// lanes of the packed 48-bit time/date word, and small lookup helpers.
package rtc_pkg;

  // RTC register addresses, in frame order (index 0..5).
  localparam logic [7:0] ADDR_SEC   = 8'h00;
  localparam logic [7:0] ADDR_MIN   = 8'h02;
  localparam logic [7:0] ADDR_HOUR  = 8'h04;
  localparam logic [7:0] ADDR_DAY   = 8'h07;
  localparam logic [7:0] ADDR_MONTH = 8'h08;
  localparam logic [7:0] ADDR_YEAR  = 8'h09;

  // Index of the last register in a frame.
  localparam logic [2:0] LAST_IDX = 3'd5;

  // Bit offsets of each byte inside the 48-bit info / wr_data word.
  localparam int unsigned OFF_HOUR  = 32'd40;
  localparam int unsigned OFF_MIN   = 32'd32;
  localparam int unsigned OFF_SEC   = 32'd24;
  localparam int unsigned OFF_DAY   = 32'd16;
  localparam int unsigned OFF_MONTH = 32'd8;
  localparam int unsigned OFF_YEAR  = 32'd0;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_READ_FRAME  = 3'd1,
    ST_WRITE_FRAME = 3'd2,
    ST_UPDATE      = 3'd3,
    ST_INIT        = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_P0   = 3'd1,
    PH_P1   = 3'd2,
    PH_P2   = 3'd3,
    PH_P3   = 3'd4,
    PH_P4   = 3'd5
  } phase_t;

  // Register address for frame index idx.
  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_addr = ADDR_SEC;
      3'd1:    reg_addr = ADDR_MIN;
      3'd2:    reg_addr = ADDR_HOUR;
      3'd3:    reg_addr = ADDR_DAY;
      3'd4:    reg_addr = ADDR_MONTH;
      3'd5:    reg_addr = ADDR_YEAR;
      default: reg_addr = ADDR_SEC;
    endcase
  endfunction

  // Byte-lane offset for frame index idx.
  function automatic int unsigned lane_off(input logic [2:0] idx);
    case (idx)
      3'd0:    lane_off = OFF_SEC;
      3'd1:    lane_off = OFF_MIN;
      3'd2:    lane_off = OFF_HOUR;
      3'd3:    lane_off = OFF_DAY;
      3'd4:    lane_off = OFF_MONTH;
      3'd5:    lane_off = OFF_YEAR;
      default: lane_off = OFF_SEC;
    endcase
  endfunction

  // Byte of a packed time/date word belonging to frame index idx.
  function automatic logic [7:0] lane_byte(input logic [47:0] word, input logic [2:0] idx);
    lane_byte = word[lane_off(idx) +: 8];
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: one RTC bus access (read or write) in five phases of
// T_PHASE clocks each. A new access is accepted while idle or in the last
// cycle of P4, so accesses can run back to back with no gap.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, write         request an access; write=1 write, 0 read
//   addr, wdata          register address and write byte (latched on accept)
//   done                 high in the last cycle of P4
//   rdata                byte sampled in the last cycle of P3
//   cs, rd, wr, ad       registered bus strobes (active-low, ad=0 address)
//   data_io              multiplexed 8-bit bus
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       ad,
  inout  tri   [7:0] data_io
);

  phase_t     phase_r;
  logic [7:0] tcnt_r;
  logic       write_r;
  logic [7:0] wdata_r;
  logic [7:0] dout_r;
  logic       oe_r;
  logic       last_s;
  logic       accept_s;

  assign last_s   = (tcnt_r == 8'(T_PHASE - 1));
  assign done     = (phase_r == PH_P4) && last_s;
  assign accept_s = start && ((phase_r == PH_IDLE) || done);
  assign data_io  = oe_r ? dout_r : 8'hzz;

  // Phase sequencing, strobe generation and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= PH_IDLE;
      tcnt_r  <= 8'd0;
      write_r <= 1'b0;
      wdata_r <= 8'h00;
      dout_r  <= 8'h00;
      oe_r    <= 1'b0;
      rdata   <= 8'h00;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      ad      <= 1'b1;
    end else if (accept_s) begin
      // Enter P0: select the chip and drive the address.
      phase_r <= PH_P0;
      tcnt_r  <= 8'd0;
      write_r <= write;
      wdata_r <= wdata;
      dout_r  <= addr;
      oe_r    <= 1'b1;
      cs      <= 1'b0;
      ad      <= 1'b0;
      rd      <= 1'b1;
      wr      <= 1'b1;
    end else if (phase_r != PH_IDLE) begin
      if (last_s) begin
        tcnt_r <= 8'd0;
        case (phase_r)
          PH_P0: begin
            phase_r <= PH_P1;
            wr      <= 1'b0;  // address latch strobe
          end
          PH_P1: begin
            phase_r <= PH_P2;
            wr      <= 1'b1;
            ad      <= 1'b1;
            oe_r    <= write_r;  // release the bus for a read
            dout_r  <= wdata_r;
          end
          PH_P2: begin
            phase_r <= PH_P3;
            if (write_r) begin
              wr <= 1'b0;
            end else begin
              rd <= 1'b0;
            end
          end
          PH_P3: begin
            phase_r <= PH_P4;
            rdata   <= data_io;
            cs      <= 1'b1;
            rd      <= 1'b1;
            wr      <= 1'b1;
            ad      <= 1'b1;
            oe_r    <= 1'b0;
          end
          PH_P4:   phase_r <= PH_IDLE;
          default: phase_r <= PH_IDLE;
        endcase
      end else begin
        tcnt_r <= tcnt_r + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: periodically reads sec/min/hour/day/month/year from an
// external RTC over a multiplexed 8-bit bus and packs them into info; writes
// a user time/date back to the chip on start_write, followed by a read frame.
// Optional macro RTC_INIT_EN: after reset, one write of INIT_VALUE to
// INIT_ADDR is issued, followed immediately by a read frame.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start_write       one-cycle write request (merged while busy)
//   wr_data           time/date to write, same packing as info
//   CS, RD, WR, AD    RTC bus strobes (active-low; AD=0 address phase)
//   data_io           multiplexed RTC bus
//   info, info_valid  packed BCD time/date and its one-cycle update pulse
//   busy              a bus frame is in progress
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int         T_PHASE        = 4,
  parameter int         REFRESH_CYCLES = 1000000,
  parameter logic [7:0] INIT_ADDR      = 8'h00,
  parameter logic [7:0] INIT_VALUE     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_write,
  input  logic [47:0] wr_data,
  output logic        CS,
  output logic        RD,
  output logic        WR,
  output logic        AD,
  inout  tri   [7:0]  data_io,
  output logic [47:0] info,
  output logic        info_valid,
  output logic        busy
);

`ifdef RTC_INIT_EN
  localparam logic INIT_AFTER_RESET = 1'b1;
`else
  localparam logic INIT_AFTER_RESET = 1'b0;
`endif

  state_t      state_r;
  logic [2:0]  idx_r;
  logic [31:0] cnt_r;
  logic        pend_r;
  logic        init_pend_r;
  logic [47:0] wr_buf_r;
  logic [7:0]  shadow_r [6];

  logic        bus_start_s;
  logic        bus_write_s;
  logic [7:0]  bus_addr_s;
  logic [7:0]  bus_wdata_s;
  logic        bus_done_s;
  logic [7:0]  bus_rdata_s;
  logic [2:0]  next_idx_s;
  logic        want_write_s;
  logic        go_s;

  assign want_write_s = pend_r | start_write;
  assign go_s         = want_write_s | (cnt_r == 32'(REFRESH_CYCLES - 1));
  assign busy         = (state_r != ST_IDLE);

  rtc_bus_cycle #(
    .T_PHASE(T_PHASE)
  ) u_bus (
    .clk    (clk),
    .reset  (reset),
    .start  (bus_start_s),
    .write  (bus_write_s),
    .addr   (bus_addr_s),
    .wdata  (bus_wdata_s),
    .done   (bus_done_s),
    .rdata  (bus_rdata_s),
    .cs     (CS),
    .rd     (RD),
    .wr     (WR),
    .ad     (AD),
    .data_io(data_io)
  );

  // Next access request; presented on the done cycle so accesses chain with no gap.
  always_comb begin
    bus_start_s = 1'b0;
    bus_write_s = 1'b0;
    bus_addr_s  = reg_addr(3'd0);
    bus_wdata_s = 8'h00;
    next_idx_s  = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (init_pend_r) begin
          bus_start_s = 1'b1;
          bus_write_s = 1'b1;
          bus_addr_s  = INIT_ADDR;
          bus_wdata_s = INIT_VALUE;
        end else begin
          // Live wr_data equals what wr_buf_r captures on this same edge.
          bus_start_s = go_s;
          bus_write_s = want_write_s;
          bus_wdata_s = lane_byte(wr_data, 3'd0);
        end
      end
      ST_INIT: begin
        bus_start_s = 1'b1;
        if (bus_done_s) begin
          bus_write_s = 1'b0;
        end else begin
          bus_write_s = 1'b1;
          bus_addr_s  = INIT_ADDR;
          bus_wdata_s = INIT_VALUE;
        end
      end
      ST_WRITE_FRAME: begin
        bus_start_s = 1'b1;
        if (bus_done_s && (idx_r == LAST_IDX)) begin
          bus_write_s = 1'b0;  // chain straight into the read-back frame
        end else begin
          next_idx_s  = bus_done_s ? (idx_r + 3'd1) : idx_r;
          bus_write_s = 1'b1;
          bus_addr_s  = reg_addr(next_idx_s);
          bus_wdata_s = lane_byte(wr_buf_r, next_idx_s);
        end
      end
      ST_READ_FRAME: begin
        if (bus_done_s && (idx_r == LAST_IDX)) begin
          bus_start_s = 1'b0;
        end else begin
          bus_start_s = 1'b1;
          next_idx_s  = bus_done_s ? (idx_r + 3'd1) : idx_r;
          bus_addr_s  = reg_addr(next_idx_s);
        end
      end
      ST_UPDATE: begin
        bus_start_s = 1'b0;
      end
      default: begin
        bus_start_s = 1'b0;
      end
    endcase
  end

  // Top FSM: refresh timing, write-request merging, shadow capture and info update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      cnt_r       <= 32'd0;
      pend_r      <= 1'b0;
      init_pend_r <= INIT_AFTER_RESET;
      wr_buf_r    <= 48'h0;
      info        <= 48'h0;
      info_valid  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_r[i] <= 8'h00;
      end
    end else begin
      info_valid <= 1'b0;
      if (start_write && (state_r != ST_IDLE)) begin
        pend_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (init_pend_r) begin
            init_pend_r <= 1'b0;
            cnt_r       <= 32'd0;
            state_r     <= ST_INIT;
          end else if (go_s) begin
            cnt_r <= 32'd0;
            idx_r <= 3'd0;
            if (want_write_s) begin
              state_r  <= ST_WRITE_FRAME;
              wr_buf_r <= wr_data;
              pend_r   <= 1'b0;
            end else begin
              state_r <= ST_READ_FRAME;
            end
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_INIT: begin
          if (bus_done_s) begin
            state_r <= ST_READ_FRAME;
            idx_r   <= 3'd0;
          end
        end
        ST_WRITE_FRAME: begin
          if (bus_done_s) begin
            if (idx_r == LAST_IDX) begin
              state_r <= ST_READ_FRAME;
              idx_r   <= 3'd0;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_READ_FRAME: begin
          if (bus_done_s) begin
            shadow_r[idx_r] <= bus_rdata_s;
            if (idx_r == LAST_IDX) begin
              state_r <= ST_UPDATE;
              idx_r   <= 3'd0;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 6; i++) begin
            info[lane_off(3'(i)) +: 8] <= shadow_r[i];
          end
          info_valid <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with T_PHASE=2, REFRESH_CYCLES=20.
// A small RTC model latches the address on WR-low during the address phase,
// stores bytes on write strobes and returns its contents while RD is low.
// The bus has a pull-up, so a released bus reads as 8'hFF.
module tb_rtc_bus_sequencer;
  import rtc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_write = 1'b0;
  logic [47:0] wr_data = 48'h0;
  logic        CS, RD, WR, AD;
  tri1  [7:0]  data_io;
  logic [47:0] info;
  logic        info_valid, busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  rtc_mem [256];
  logic [7:0]  lat_addr = 8'h00;
  logic        prev_wr = 1'b1;
  logic        prev_rd = 1'b1;
  logic [16:0] log_e [512];
  int          log_n = 0;
  int          overlap_n = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(
    .T_PHASE(2), .REFRESH_CYCLES(20), .INIT_ADDR(8'h02), .INIT_VALUE(8'h10)
  ) dut (
    .clk(clk), .reset(reset), .start_write(start_write), .wr_data(wr_data),
    .CS(CS), .RD(RD), .WR(WR), .AD(AD), .data_io(data_io),
    .info(info), .info_valid(info_valid), .busy(busy)
  );

  assign data_io = (!CS && !RD) ? rtc_mem[lat_addr] : 8'hzz;

  // RTC model and bus-event log: entry = {write, addr, data}.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
      rtc_mem[ADDR_SEC] = 8'h45;  rtc_mem[ADDR_MIN] = 8'h30;
      rtc_mem[ADDR_HOUR] = 8'h12; rtc_mem[ADDR_DAY] = 8'h25;
      rtc_mem[ADDR_MONTH] = 8'h06; rtc_mem[ADDR_YEAR] = 8'h24;
    end else begin
      if (!RD && !WR) overlap_n++;
      if (!CS && !AD && !WR) lat_addr = data_io;
      if (!CS && AD && !WR && prev_wr) begin
        rtc_mem[lat_addr] = data_io;
        if (log_n < 512) begin log_e[log_n] = {1'b1, lat_addr, data_io}; log_n++; end
      end
      if (!CS && !RD && prev_rd) begin
        if (log_n < 512) begin log_e[log_n] = {1'b0, lat_addr, data_io}; log_n++; end
      end
    end
    prev_wr = WR;
    prev_rd = RD;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs_low(input string tag, input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (CS !== 1'b0 && n < limit);
    if (CS !== 1'b0) check({tag, "_timeout"}, 64'(CS), 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (info_valid !== 1'b1 && n < limit);
    if (info_valid !== 1'b1) check({tag, "_timeout"}, 64'(info_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int wcount;
    logic [9:0] cs_t, ad_t, wr_t, rd_t, hz_t;
    logic [7:0] addr_t [6];
    logic [7:0] exp_r [6];
    logic [7:0] exp_w [6];
    logic [7:0] exp_c [6];
    addr_t = '{ADDR_SEC, ADDR_MIN, ADDR_HOUR, ADDR_DAY, ADDR_MONTH, ADDR_YEAR};
    exp_r  = '{8'h45, 8'h30, 8'h12, 8'h25, 8'h06, 8'h24};
    exp_w  = '{8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};
    exp_c  = '{8'h33, 8'h22, 8'h11, 8'h44, 8'h55, 8'h66};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_strobes", 64'({CS, RD, WR, AD}), 64'h0F);
    check("reset_bus", 64'(data_io), 64'hFF);
    check("reset_info", 64'(info), 64'h0);
    check("reset_valid_busy", 64'({info_valid, busy}), 64'h0);
    reset = 1'b0;

`ifdef RTC_INIT_EN
    base = log_n;
    wait_cs_low("init_start", 20, n);
    check("init_start_delay", 64'(n), 64'd1);
    wait_valid("init_frame", 300, n);
    check("init_entries", 64'(log_n - base), 64'd7);
    check("init_write", 64'(log_e[base]), 64'({1'b1, 8'h02, 8'h10}));
    for (int i = 0; i < 6; i++)
      check("init_read_addr", 64'(log_e[base + 1 + i][16:8]), 64'({1'b0, addr_t[i]}));
`else
    // First refresh read frame and single-access phase timing.
    base = log_n;
    wait_cs_low("first_refresh", 100, n);
    check("refresh_delay", 64'(n), 64'd20);
    check("busy_in_frame", 64'(busy), 64'd1);
    check("p0_addr", 64'(data_io), 64'(ADDR_SEC));
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      cs_t[c] = CS; ad_t[c] = AD; wr_t[c] = WR; rd_t[c] = RD;
      hz_t[c] = (data_io === 8'hFF);
    end
    check("cs_trace", 64'(cs_t), 64'(10'b1100000000));
    check("ad_trace", 64'(ad_t), 64'(10'b1111110000));
    check("wr_trace", 64'(wr_t), 64'(10'b1111110011));
    check("rd_trace", 64'(rd_t), 64'(10'b1100111111));
    check("hiz_trace", 64'(hz_t & 10'b1100111111), 64'(10'b1100110000));
    wait_valid("read_frame", 200, n);
    check("frame_len", 64'(9 + n), 64'd61);
    check("read_info", 64'(info), 64'h123045250624);
    for (int i = 0; i < 6; i++)
      check("read_seq", 64'(log_e[base + i]), 64'({1'b0, addr_t[i], exp_r[i]}));
    check("read_entries", 64'(log_n - base), 64'd6);
    @(negedge clk);
    check("valid_one_cycle", 64'({info_valid, busy}), 64'h0);

    // Write frame from idle, followed by a read-back frame.
    base = log_n;
    wr_data = 48'h235958311299;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    wait_valid("write_frame", 400, n);
    check("write_entries", 64'(log_n - base), 64'd12);
    for (int i = 0; i < 6; i++) begin
      check("write_seq", 64'(log_e[base + i]), 64'({1'b1, addr_t[i], exp_w[i]}));
      check("write_readback", 64'(log_e[base + 6 + i]), 64'({1'b0, addr_t[i], exp_w[i]}));
    end
    check("write_info", 64'(info), 64'h235958311299);

    // Write requests during a refresh frame; wr_data changes before the frame ends.
    base = log_n;
    wait_cs_low("refresh_2", 100, n);
    repeat (5) @(negedge clk);
    wr_data = 48'h010203040506;
    start_write = 1'b1; @(negedge clk); start_write = 1'b0;
    repeat (3) @(negedge clk);
    start_write = 1'b1; @(negedge clk); start_write = 1'b0;
    repeat (20) @(negedge clk);
    wr_data = 48'h112233445566;
    wait_valid("collision_read", 200, n);
    wait_valid("collision_write", 400, n);
    check("collision_info", 64'(info), 64'h112233445566);
    for (int i = 0; i < 6; i++)
      check("collision_write_seq", 64'(log_e[base + 6 + i]), 64'({1'b1, addr_t[i], exp_c[i]}));
    repeat (40) @(negedge clk);
    wcount = 0;
    for (int i = base; i < log_n; i++) if (log_e[i][16]) wcount++;
    check("collision_one_write_frame", 64'(wcount), 64'd6);

    // Reset asserted during P3 of the third access.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_cs_low("refresh_after_reset", 100, n);
    check("refresh_delay_2", 64'(n), 64'd20);
    repeat (26) @(negedge clk);
    check("in_p3", 64'({RD, AD}), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", 64'({CS, RD, WR, AD}), 64'h0F);
    check("abort_bus", 64'(data_io), 64'hFF);
    check("abort_info", 64'(info), 64'h0);
    check("abort_valid_busy", 64'({info_valid, busy}), 64'h0);
    reset = 1'b0;
`endif

    check("rd_wr_overlap", 64'(overlap_n), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
